// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter.
//   arb_state_e : round-sequencing states (3-bit encoding)
//   cnt_width   : width of a counter that must hold values 0..limit
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ArbIdle = 3'd0,
    ArbDRd  = 3'd1,
    ArbDWr  = 3'd2,
    ArbIfRd = 3'd3,
    ArbResp = 3'd4
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Memory-handshake watchdog: counts stalled request cycles and flags expiry.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   clear_i  : restart the count (state entry); wins over count_i
//   count_i  : a request is outstanding and unacknowledged this cycle
//   expire_o : count has reached Timeout (never asserted when Timeout == 0)
module mem_arbiter_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CntW = cnt_width(Timeout);
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturates at CntMax so a stuck request can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (Timeout != 0) && (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One round per pipeline advance: data read (plus write for stores), then fetch.
//   clock/reset        : rising-edge clock, synchronous active-low reset
//   if_req/if_addr     : fetch request and address; if_inst/if_valid return the word
//   d_load/d_store     : data request (both set = store); d_addr address
//   d_wdata            : merged store word, sampled on entry to the write phase
//   d_rdata/d_valid    : loaded (or pre-store) word and per-round served pulse
//   stall              : pipeline freeze while the round is in progress
//   m_req/m_we/m_addr/m_wdata/m_rdata/m_ack : memory handshake
//   bus_err            : sticky flag set when the watchdog aborts an access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_inst,
  output logic            if_valid,
  input  logic            d_load,
  input  logic            d_store,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            stall,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack,
  output logic            bus_err
);

  arb_state_e      state_q, state_d;
  logic            data_q, data_d;
  logic            store_q, store_d;
  logic            fetch_q, fetch_d;
  logic [XLEN-1:0] daddr_q, daddr_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            bus_err_q, bus_err_d;

  logic            expire;
  logic            done;
  logic [XLEN-1:0] rdata_in;
  logic            wd_clear;
  logic            wd_count;

  // A real acknowledge wins over a coincident expiry.
  assign done     = m_ack | expire;
  assign rdata_in = m_ack ? m_rdata : '0;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    store_d   = store_q;
    fetch_d   = fetch_q;
    daddr_d   = daddr_q;
    iaddr_d   = iaddr_q;
    wdata_d   = wdata_q;
    if_inst_d = if_inst_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = bus_err_q;
    stall     = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        stall = d_load | d_store | if_req;
        if (d_load | d_store | if_req) begin
          // Freeze the whole request; inputs are ignored until the round ends.
          data_d  = d_load | d_store;
          store_d = d_store;
          fetch_d = if_req;
          daddr_d = d_addr;
          iaddr_d = if_addr;
          state_d = (d_load | d_store) ? ArbDRd : ArbIfRd;
        end
      end
      ArbDRd: begin
        stall  = 1'b1;
        m_req  = 1'b1;
        m_addr = daddr_q;
        if (done) begin
          d_rdata_d = rdata_in;
          if (store_q) begin
            wdata_d = d_wdata;
            state_d = ArbDWr;
          end else begin
            state_d = fetch_q ? ArbIfRd : ArbResp;
          end
        end
      end
      ArbDWr: begin
        stall   = 1'b1;
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = daddr_q;
        m_wdata = wdata_q;
        if (done) begin
          state_d = fetch_q ? ArbIfRd : ArbResp;
        end
      end
      ArbIfRd: begin
        stall  = 1'b1;
        m_req  = 1'b1;
        m_addr = iaddr_q;
        if (done) begin
          if_inst_d = rdata_in;
          state_d   = ArbResp;
        end
      end
      ArbResp: begin
        d_valid  = data_q;
        if_valid = fetch_q;
        state_d  = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase

    if (m_req && !m_ack && expire) begin
      bus_err_d = 1'b1;
    end
  end

  // Restart the watchdog whenever the state changes.
  assign wd_clear = (state_d != state_q);
  assign wd_count = m_req & ~m_ack;

  mem_arbiter_wdog #(
    .Timeout(TIMEOUT)
  ) u_wdog (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (wd_clear),
    .count_i (wd_count),
    .expire_o(expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ArbIdle;
      data_q    <= 1'b0;
      store_q   <= 1'b0;
      fetch_q   <= 1'b0;
      daddr_q   <= '0;
      iaddr_q   <= '0;
      wdata_q   <= '0;
      if_inst_q <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      store_q   <= store_d;
      fetch_q   <= fetch_d;
      daddr_q   <= daddr_d;
      iaddr_q   <= iaddr_d;
      wdata_q   <= wdata_d;
      if_inst_q <= if_inst_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign if_inst = if_inst_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;

endmodule
